// File: rtl/lsu_mem_stage_if.sv
// Bus bundle between the execute/memory pipeline register and the LSU memory stage.
// The master side presents the M-stage access and the switch inputs. The slave side
// (lsu_mem_stage) returns the W-stage load data, the misalign pulse and the LED registers.
//   i_addr/i_st_data/i_wren/i_rden/i_funct3 : M-stage access
//   i_io_sw                                 : raw asynchronous switch inputs
//   o_ld_data/o_misalign                    : W-stage results
//   o_io_ledr/o_io_ledg                     : LED registers
interface lsu_mem_stage_if;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic        i_wren;
  logic        i_rden;
  logic [2:0]  i_funct3;
  logic [31:0] i_io_sw;
  logic [31:0] o_ld_data;
  logic [31:0] o_io_ledr;
  logic [31:0] o_io_ledg;
  logic        o_misalign;

  modport master (
    output i_addr, i_st_data, i_wren, i_rden, i_funct3, i_io_sw,
    input  o_ld_data, o_io_ledr, o_io_ledg, o_misalign
  );

  modport slave (
    input  i_addr, i_st_data, i_wren, i_rden, i_funct3, i_io_sw,
    output o_ld_data, o_io_ledr, o_io_ledg, o_misalign
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: byte/half/word loads and stores to a synchronous-read data RAM
// and to memory-mapped LEDR/LEDG registers and a synchronized switch port.
// Load data is aligned and extended in W, one cycle after the access in M.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : lsu_mem_stage_if.slave (M-stage access in, W-stage results out)
module lsu_mem_stage #(
  parameter int unsigned DMEM_AW   = 11,
  parameter logic [31:0] DMEM_BASE = 32'h0000_2000
) (
  input logic            i_clk,
  input logic            i_rst_n,
  lsu_mem_stage_if.slave bus
);

  localparam logic [31:0] RamBytes = 32'(1) << (DMEM_AW + 2);
  localparam logic [1:0]  SizeB = 2'd0;
  localparam logic [1:0]  SizeH = 2'd1;
  localparam logic [1:0]  SizeW = 2'd2;

  // ---------------- M stage: decode ----------------
  logic [31:0] ram_off;
  logic        sel_ram, sel_ledr, sel_ledg, sel_sw;
  logic [1:0]  size;
  logic        f3_ok, misalign, st_go, ld_go;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [DMEM_AW-1:0] ram_idx;

  // Addresses below the base wrap to huge offsets, so one compare covers both bounds.
  assign ram_off  = bus.i_addr - DMEM_BASE;
  assign sel_ram  = ram_off < RamBytes;
  assign ram_idx  = ram_off[DMEM_AW+1:2];
  assign sel_ledr = bus.i_addr[31:2] == 30'h0000_1C00;
  assign sel_ledg = bus.i_addr[31:2] == 30'h0000_1C04;
  assign sel_sw   = bus.i_addr[31:2] == 30'h0000_1E00;

  always_comb begin
    size  = SizeB;
    f3_ok = 1'b1;
    case (bus.i_funct3)
      3'b000, 3'b100: size = SizeB;
      3'b001, 3'b101: size = SizeH;
      3'b010:         size = SizeW;
      default:        f3_ok = 1'b0;
    endcase
  end

  assign misalign = f3_ok && (bus.i_wren || bus.i_rden) &&
                    (((size == SizeH) && bus.i_addr[0]) ||
                     ((size == SizeW) && (bus.i_addr[1:0] != 2'b00)));
  assign st_go    = bus.i_wren && f3_ok && !misalign;
  // A simultaneous store and load is treated as a store only.
  assign ld_go    = bus.i_rden && !bus.i_wren && f3_ok && !misalign;

  always_comb begin
    be    = 4'b0000;
    wdata = bus.i_st_data;
    if (st_go) begin
      unique case (size)
        SizeB: begin
          be    = 4'b0001 << bus.i_addr[1:0];
          wdata = {4{bus.i_st_data[7:0]}};
        end
        SizeH: begin
          be    = bus.i_addr[1] ? 4'b1100 : 4'b0011;
          wdata = {2{bus.i_st_data[15:0]}};
        end
        default: be = 4'b1111;
      endcase
    end
  end

  // ---------------- Data RAM (not reset) ----------------
  logic [31:0] mem [2**DMEM_AW];
  logic [31:0] ram_rdata_q;

  always_ff @(posedge i_clk) begin
    // Writes are blocked while reset is held so a store at a reset edge is dropped.
    if (i_rst_n && sel_ram) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[ram_idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    ram_rdata_q <= mem[ram_idx];
  end

  // ---------------- IO registers and switch synchronizer ----------------
  logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d;
  logic [31:0] sw_meta_q, sw_sync_q;
  logic [31:0] io_rdata_d;

  always_comb begin
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    for (int k = 0; k < 4; k++) begin
      if (be[k] && sel_ledr) ledr_d[8*k +: 8] = wdata[8*k +: 8];
      if (be[k] && sel_ledg) ledg_d[8*k +: 8] = wdata[8*k +: 8];
    end
    if (sel_ledr)      io_rdata_d = ledr_q;
    else if (sel_ledg) io_rdata_d = ledg_q;
    else if (sel_sw)   io_rdata_d = sw_sync_q;
    else               io_rdata_d = 32'h0;
  end

  // ---------------- M -> W pipeline state ----------------
  logic        ld_valid_q, ram_sel_q, misalign_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] io_rdata_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q     <= 32'h0;
      ledg_q     <= 32'h0;
      sw_meta_q  <= 32'h0;
      sw_sync_q  <= 32'h0;
      ld_valid_q <= 1'b0;
      ram_sel_q  <= 1'b0;
      misalign_q <= 1'b0;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
      io_rdata_q <= 32'h0;
    end else begin
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      sw_meta_q  <= bus.i_io_sw;
      sw_sync_q  <= sw_meta_q;
      ld_valid_q <= ld_go;
      ram_sel_q  <= sel_ram;
      misalign_q <= misalign;
      off_q      <= bus.i_addr[1:0];
      f3_q       <= bus.i_funct3;
      io_rdata_q <= io_rdata_d;
    end
  end

  // ---------------- W stage: align and extend ----------------
  logic [31:0] word, shifted, ld_data;

  always_comb begin
    word    = ram_sel_q ? ram_rdata_q : io_rdata_q;
    shifted = word >> {off_q, 3'b000};
    ld_data = 32'h0;
    if (ld_valid_q) begin
      case (f3_q)
        3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
        3'b100:  ld_data = {24'h0, shifted[7:0]};
        3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
        3'b101:  ld_data = {16'h0, shifted[15:0]};
        3'b010:  ld_data = shifted;
        default: ld_data = 32'h0;
      endcase
    end
  end

  assign bus.o_ld_data  = ld_data;
  assign bus.o_misalign = misalign_q;
  assign bus.o_io_ledr  = ledr_q;
  assign bus.o_io_ledg  = ledg_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_stage_if bus ();

  lsu_mem_stage #(.DMEM_AW(11), .DMEM_BASE(32'h0000_2000)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    string       name;
    logic        wren;
    logic        rden;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] exp_ld;
    logic        exp_mis;
    logic [31:0] exp_ledr;
    logic [31:0] exp_ledg;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] ld;
    logic        mis;
    logic [31:0] ledr;
    logic [31:0] ledg;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] cur_r = 32'h0;
  logic [31:0] cur_g = 32'h0;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input string name, input logic wr, input logic rd, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] st, input logic [31:0] ld,
                     input logic mis);
    vec_t v;
    v.name = name; v.wren = wr; v.rden = rd; v.f3 = f3; v.addr = addr; v.st = st;
    v.exp_ld = ld; v.exp_mis = mis; v.exp_ledr = cur_r; v.exp_ledg = cur_g;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] st);
    bus.i_wren = wr; bus.i_rden = rd; bus.i_funct3 = f3;
    bus.i_addr = addr; bus.i_st_data = st;
  endtask

  initial begin
    exp_t e;
    drive(1'b0, 1'b0, W, 32'h0, 32'h0);
    bus.i_io_sw = 32'hDEAD_BEEF;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_ld", bus.o_ld_data, 32'h0);
    check("rst_ledr", bus.o_io_ledr, 32'h0);
    check("rst_ledg", bus.o_io_ledg, 32'h0);
    check("rst_mis", {31'h0, bus.o_misalign}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- vector table ----
    add("sw_ram",    1, 0, W,  32'h2000, 32'h1234_5678, 32'h0, 0);
    add("lw_ram",    0, 1, W,  32'h2000, 32'h0, 32'h1234_5678, 0);
    add("lb_2003",   0, 1, B,  32'h2003, 32'h0, 32'h0000_0012, 0);
    add("lh_2000",   0, 1, H,  32'h2000, 32'h0, 32'h0000_5678, 0);
    add("lb_2000",   0, 1, B,  32'h2000, 32'h0, 32'h0000_0078, 0);
    add("lh_2002",   0, 1, H,  32'h2002, 32'h0, 32'h0000_1234, 0);
    add("sw_zero",   1, 0, W,  32'h2004, 32'h0, 32'h0, 0);
    add("sb_ff",     1, 0, B,  32'h2005, 32'h0000_00FF, 32'h0, 0);
    add("lb_neg",    0, 1, B,  32'h2005, 32'h0, 32'hFFFF_FFFF, 0);
    add("lbu_ff",    0, 1, BU, 32'h2005, 32'h0, 32'h0000_00FF, 0);
    add("lw_sb",     0, 1, W,  32'h2004, 32'h0, 32'h0000_FF00, 0);
    cur_r = 32'hA5A5_A5A5;
    add("sw_ledr",   1, 0, W,  32'h7000, 32'hA5A5_A5A5, 32'h0, 0);
    cur_g = 32'h1111_0000;
    add("sh_ledg",   1, 0, H,  32'h7012, 32'h0000_1111, 32'h0, 0);
    add("lw_ledr",   0, 1, W,  32'h7000, 32'h0, 32'hA5A5_A5A5, 0);
    add("lhu_ledg",  0, 1, HU, 32'h7012, 32'h0, 32'h0000_1111, 0);
    add("lh_ledr",   0, 1, H,  32'h7002, 32'h0, 32'hFFFF_A5A5, 0);
    add("lbu_ledr",  0, 1, BU, 32'h7001, 32'h0, 32'h0000_00A5, 0);
    add("lw_sw",     0, 1, W,  32'h7800, 32'h0, 32'hDEAD_BEEF, 0);
    add("st_sw",     1, 0, W,  32'h7800, 32'h0, 32'h0, 0);
    add("lw_sw2",    0, 1, W,  32'h7800, 32'h0, 32'hDEAD_BEEF, 0);
    add("sh_mis",    1, 0, H,  32'h2001, 32'h0000_BEEF, 32'h0, 1);
    add("lw_after",  0, 1, W,  32'h2000, 32'h0, 32'h1234_5678, 0);
    add("lw_mis",    0, 1, W,  32'h2002, 32'h0, 32'h0, 1);
    add("lhu_mis",   0, 1, HU, 32'h2003, 32'h0, 32'h0, 1);
    add("lw_unmap",  0, 1, W,  32'h9000, 32'h0, 32'h0, 0);
    add("sw_unmap",  1, 0, W,  32'h9000, 32'h0000_0077, 32'h0, 0);
    add("wr_rd",     1, 1, W,  32'h2008, 32'hCAFE_F00D, 32'h0, 0);
    add("lw_wr_rd",  0, 1, W,  32'h2008, 32'h0, 32'hCAFE_F00D, 0);
    add("ld_f3bad",  0, 1, 3'b011, 32'h2000, 32'h0, 32'h0, 0);
    add("st_f3bad",  1, 0, 3'b110, 32'h2000, 32'h0, 32'h0, 0);
    add("lw_f3bad",  0, 1, W,  32'h2000, 32'h0, 32'h1234_5678, 0);
    add("idle",      0, 0, W,  32'h2000, 32'h0, 32'h0, 0);
    cur_g = 32'h1111_0080;
    add("sb_ledg",   1, 0, B,  32'h7010, 32'h0000_0080, 32'h0, 0);
    add("lb_ledg",   0, 1, B,  32'h7010, 32'h0, 32'hFFFF_FF80, 0);
    add("sw_top",    1, 0, W,  32'h3FFC, 32'h0000_55AA, 32'h0, 0);
    add("lw_top",    0, 1, W,  32'h3FFC, 32'h0, 32'h0000_55AA, 0);
    add("sw_past",   1, 0, W,  32'h4000, 32'h0000_0077, 32'h0, 0);
    add("lw_past",   0, 1, W,  32'h4000, 32'h0, 32'h0, 0);
    add("lw_below",  0, 1, W,  32'h1FFC, 32'h0, 32'h0, 0);
    add("lw_alias",  0, 1, W,  32'h2000, 32'h0, 32'h1234_5678, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].wren, vecs[i].rden, vecs[i].f3, vecs[i].addr, vecs[i].st);
      e.name = vecs[i].name; e.ld = vecs[i].exp_ld; e.mis = vecs[i].exp_mis;
      e.ledr = vecs[i].exp_ledr; e.ledg = vecs[i].exp_ledg;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s: scoreboard empty, got %h expected an entry", vecs[i].name,
                 bus.o_ld_data);
      end else begin
        e = sb.pop_front();
        check({e.name, "_ld"}, bus.o_ld_data, e.ld);
        check({e.name, "_mis"}, {31'h0, bus.o_misalign}, {31'h0, e.mis});
        check({e.name, "_ledr"}, bus.o_io_ledr, e.ledr);
        check({e.name, "_ledg"}, bus.o_io_ledg, e.ledg);
      end
    end

    // ---- switch synchronizer latency ----
    @(negedge clk);
    bus.i_io_sw = 32'h1357_2468;
    drive(1'b0, 1'b1, W, 32'h7800, 32'h0);
    @(posedge clk); #1;
    check("sync_e1", bus.o_ld_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("sync_e2", bus.o_ld_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("sync_e3", bus.o_ld_data, 32'h1357_2468);

    // ---- reset during operation ----
    @(negedge clk);
    drive(1'b0, 1'b1, W, 32'h2000, 32'h0);
    @(posedge clk); #1;
    check("pre_rst_ld", bus.o_ld_data, 32'h1234_5678);
    #1;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, W, 32'h7000, 32'h0000_0001);
    #1;
    check("rst_async_ld", bus.o_ld_data, 32'h0);
    check("rst_async_ledr", bus.o_io_ledr, 32'h0);
    check("rst_async_ledg", bus.o_io_ledg, 32'h0);
    @(posedge clk); #1;
    check("rst_st_ledr", bus.o_io_ledr, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, W, 32'h2000, 32'h0000_0099);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, W, 32'h2000, 32'h0);
    @(posedge clk); #1;
    check("post_rst_ld", bus.o_ld_data, 32'h0);
    check("post_rst_mis", {31'h0, bus.o_misalign}, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, W, 32'h2000, 32'h0);
    @(posedge clk); #1;
    check("post_rst_ram", bus.o_ld_data, 32'h1234_5678);
    check("post_rst_ledr", bus.o_io_ledr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Memory-access stage of the five-stage RISC-V pipeline. Consumes the M-stage address, store data and LSU control produced by the execute/memory pipeline register. Performs byte/half/word loads and stores against on-chip data RAM and memory-mapped IO (red LEDs, green LEDs, switches). Delivers aligned, extended load data to the write-back stage one cycle later.

## Interface
Parameters:
- DMEM_AW, 11, word-address width of data RAM (2^11 words = 8 KiB)
- DMEM_BASE, 32'h0000_2000, byte base address of data RAM

Ports:
- i_clk  in  1  pipeline clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_addr  in  32  byte address (alu_dataM)
- i_st_data  in  32  store data (rs2_dataM), LSB-justified
- i_wren  in  1  store request in M (lsu_wrenM)
- i_rden  in  1  load request in M
- i_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_io_sw  in  32  asynchronous switch inputs
- o_ld_data  out  32  load result for W (ld_dataW)
- o_io_ledr  out  32  red LED register
- o_io_ledg  out  32  green LED register
- o_misalign  out  1  one-cycle pulse in W flagging a misaligned access

## Operation
- Address decode on i_addr:
  - DMEM_BASE .. DMEM_BASE+4·2^DMEM_AW−1 → RAM
  - 0x0000_7000..7003 → LEDR
  - 0x0000_7010..7013 → LEDG
  - 0x0000_7800..7803 → SW (read-only)
  - anything else → unmapped: stores ignored, loads return 0
- Alignment: byte access is always legal. Half requires addr[0]=0. Word requires addr[1:0]=00. Otherwise misaligned.
  - Misaligned store: no state changes.
  - Misaligned load: returns 0.
  - In both cases o_misalign=1 in the following cycle.
- Stores, written at the clock edge:
  - Byte enables: SB → 1 lane at addr[1:0]; SH → 2 lanes at addr[1]; SW → all 4.
  - Store data lane-shifted: byte k of the word gets i_st_data[7:0] (SB) or the matching half.
  - Same rules apply to LEDR/LEDG byte lanes.
  - funct3 values 011/11x: store ignored, load returns 0, no misalign flag.
- Loads:
  - RAM is synchronous-read. addr[1:0], funct3 and the region select are registered alongside it.
  - In W, select the byte/half from the registered word.
  - Sign-extend for B/H; zero-extend for BU/HU.
  - LEDR/LEDG reads return the register value. SW reads return the synchronized switch value.
- i_wren and i_rden both high: treated as a store only; o_ld_data = 0 next cycle.
- Switch path: 2-flop synchronizer on i_io_sw; loads see the second-stage value.
- No stall input: M→W always advances. The hazard unit must not stall this stage.

## Timing
- Store at edge k: visible to a load issued in cycle k+1 (read-after-write through RAM, no bypass needed).
- Load issued in M cycle k: o_ld_data valid in W cycle k+1. It stays valid only that cycle, then reflects the next access.
- o_io_ledr/o_io_ledg change at the edge that commits the store.
- Switch change to load-visible value: 2 edges.
- Idle (no i_rden): o_ld_data = 0 next cycle; o_misalign = 0.
- Reset state (asynchronous assert, synchronous-edge release):
  - o_ld_data = 0, o_io_ledr = 0, o_io_ledg = 0, o_misalign = 0, synchronizer = 0.
  - RAM contents are not reset.
- Reset during operation:
  - Any store presented at an edge while i_rst_n=0 is suppressed, including RAM writes.
  - Any load in flight is discarded; o_ld_data = 0 until the first load after release.

## Test plan
- SW 0x1234_5678 to 0x2000 → LW 0x2000 next cycle yields 0x1234_5678. Then LB 0x2003 → 0x0000_0012, LH 0x2000 → 0x0000_5678.
- SB 0xFF to 0x2001 over 0x0000_0000 → LB 0x2001 = 0xFFFF_FFFF, LBU 0x2001 = 0x0000_00FF, LW 0x2000 = 0x0000_FF00.
- SW 0xA5A5_A5A5 to 0x7000 → o_io_ledr = 0xA5A5_A5A5 after that edge. SH 0x1111 to 0x7012 → o_io_ledg = 0x1111_0000.
- i_io_sw = 0xDEAD_BEEF, wait 2 cycles → LW 0x7800 = 0xDEAD_BEEF. SW to 0x7800 → no change to any state.
- SH to 0x2001 and LW 0x2002 → o_misalign = 1 the next cycle, RAM unchanged, load result 0. LW 0x9000 (unmapped) → 0, o_misalign = 0.
- Assert i_rst_n=0 mid-sequence with SW 0x1 to 0x7000 pending → o_io_ledr = 0, o_ld_data = 0. After release, LW of a previously stored RAM word still returns its old value.
